// File: rtl/ddf_flux_scheduler_if.sv
// ============================================================================
// Module      : ddf_flux_scheduler_if
// Description : Handshake bundle between the flux scheduler and its FIFOs/actor.
//               Stats ports exist only when DDF_SCHED_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddf_flux_scheduler_if #(
    parameter int FLUX      = 2,
    parameter int PORTS     = 2,
    parameter int TAG_WIDTH = $clog2(FLUX),
    parameter int SEL_WIDTH = $clog2(PORTS),
    parameter int CNT_WIDTH = 16
);
    logic                        en;
    logic [FLUX-1:0]             nda_empty;
    logic [FLUX*SEL_WIDTH-1:0]   nda_head;
    logic [PORTS*FLUX-1:0]       in_empty;
    logic [FLUX-1:0]             out_full;
    logic [FLUX-1:0]             nda_read;
    logic [PORTS*FLUX-1:0]       in_read;
    logic                        fire;
    logic [TAG_WIDTH-1:0]        fire_tag;
    logic [SEL_WIDTH-1:0]        fire_port;
    logic                        busy;
    logic                        err_sel;
`ifdef DDF_SCHED_STATS_EN
    logic [TAG_WIDTH-1:0]        stat_sel;
    logic [CNT_WIDTH-1:0]        stat_count;

    modport master (
        output en, nda_empty, nda_head, in_empty, out_full, stat_sel,
        input  nda_read, in_read, fire, fire_tag, fire_port, busy, err_sel, stat_count
    );
    modport slave (
        input  en, nda_empty, nda_head, in_empty, out_full, stat_sel,
        output nda_read, in_read, fire, fire_tag, fire_port, busy, err_sel, stat_count
    );
`else
    modport master (
        output en, nda_empty, nda_head, in_empty, out_full,
        input  nda_read, in_read, fire, fire_tag, fire_port, busy, err_sel
    );
    modport slave (
        input  en, nda_empty, nda_head, in_empty, out_full,
        output nda_read, in_read, fire, fire_tag, fire_port, busy, err_sel
    );
`endif
endinterface

`default_nettype wire

// File: rtl/ddf_flux_scheduler.sv
// ============================================================================
// Module      : ddf_flux_scheduler
// Description : Round-robin firing controller for a multi-flux DDF pick actor.
//               Optional per-flux fire counters under DDF_SCHED_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddf_flux_scheduler #(
    parameter int FLUX      = 2,
    parameter int PORTS     = 2,
    parameter int TAG_WIDTH = $clog2(FLUX),
    parameter int SEL_WIDTH = $clog2(PORTS),
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    ddf_flux_scheduler_if.slave   bus
);

    localparam logic [SEL_WIDTH:0] c_ports = PORTS[SEL_WIDTH:0];
    localparam logic [TAG_WIDTH:0] c_flux  = FLUX[TAG_WIDTH:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIRE = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [TAG_WIDTH-1:0]   r_rr_ptr;
    logic [FLUX-1:0]        r_nda_read;
    logic [PORTS*FLUX-1:0]  r_in_read;
    logic                   r_fire;
    logic [TAG_WIDTH-1:0]   r_fire_tag;
    logic [SEL_WIDTH-1:0]   r_fire_port;
    logic                   r_busy;
    logic                   r_err_sel;

    logic [FLUX-1:0]        w_ready;
    logic [FLUX-1:0]        w_bad;
    logic [FLUX-1:0]        w_rot;
    logic [2*FLUX-1:0]      w_ready_x2;
    logic                   w_grant_valid;
    logic [TAG_WIDTH-1:0]   w_grant_tag;
    logic [SEL_WIDTH-1:0]   w_grant_sel;
    logic                   w_grant_bad;
    logic [FLUX-1:0]        w_nda_onehot;
    logic [PORTS*FLUX-1:0]  w_in_onehot;

    // A bad select is ready on its control token alone so it can be drained.
    for (genvar gf = 0; gf < FLUX; gf++) begin : g_flux
        logic [SEL_WIDTH-1:0] w_sel;
        logic                 w_data_ok;

        assign w_sel = bus.nda_head[gf*SEL_WIDTH +: SEL_WIDTH];

        always_comb begin
            w_data_ok = 1'b0;
            for (int p = 0; p < PORTS; p++) begin
                if (w_sel == SEL_WIDTH'(p) && !bus.in_empty[p*FLUX+gf])
                    w_data_ok = 1'b1;
            end
        end

        assign w_bad[gf]   = ({1'b0, w_sel} >= c_ports);
        assign w_ready[gf] = w_bad[gf] ? !bus.nda_empty[gf]
                           : (!bus.nda_empty[gf] && !bus.out_full[gf] && w_data_ok);
    end

    assign w_ready_x2 = {w_ready, w_ready} >> r_rr_ptr;
    assign w_rot      = w_ready_x2[FLUX-1:0];

    always_comb begin
        logic [TAG_WIDTH:0] w_sum;
        w_grant_valid = 1'b0;
        w_grant_tag   = '0;
        w_sum         = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (!w_grant_valid && w_rot[i]) begin
                w_grant_valid = 1'b1;
                w_sum = {1'b0, r_rr_ptr} + (TAG_WIDTH+1)'(i);
                if (w_sum >= c_flux)
                    w_sum = w_sum - c_flux;
                w_grant_tag = w_sum[TAG_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_grant_sel  = '0;
        w_grant_bad  = 1'b0;
        w_nda_onehot = '0;
        w_in_onehot  = '0;
        for (int f = 0; f < FLUX; f++) begin
            if (w_grant_tag == TAG_WIDTH'(f)) begin
                w_grant_sel     = bus.nda_head[f*SEL_WIDTH +: SEL_WIDTH];
                w_grant_bad     = w_bad[f];
                w_nda_onehot[f] = 1'b1;
            end
        end
        for (int p = 0; p < PORTS; p++) begin
            for (int f = 0; f < FLUX; f++) begin
                w_in_onehot[p*FLUX+f] = (w_grant_tag == TAG_WIDTH'(f)) &&
                                        (w_grant_sel == SEL_WIDTH'(p)) && !w_grant_bad;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_nda_read  <= '0;
            r_in_read   <= '0;
            r_fire      <= 1'b0;
            r_fire_tag  <= '0;
            r_fire_port <= '0;
            r_busy      <= 1'b0;
            r_err_sel   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.en && w_grant_valid) begin
                        r_state     <= S_FIRE;
                        r_fire_tag  <= w_grant_tag;
                        r_fire_port <= w_grant_sel;
                        r_nda_read  <= w_nda_onehot;
                        r_in_read   <= w_in_onehot;
                        r_fire      <= !w_grant_bad;
                        r_err_sel   <= w_grant_bad;
                        r_busy      <= 1'b1;
                    end
                end
                S_FIRE: begin
                    r_nda_read <= '0;
                    r_in_read  <= '0;
                    r_fire     <= 1'b0;
                    r_err_sel  <= 1'b0;
                    r_rr_ptr   <= (r_fire_tag == TAG_WIDTH'(FLUX-1)) ? '0
                                : r_fire_tag + 1'b1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_nda_read <= '0;
                    r_in_read  <= '0;
                    r_fire     <= 1'b0;
                    r_err_sel  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.nda_read  = r_nda_read;
    assign bus.in_read   = r_in_read;
    assign bus.fire      = r_fire;
    assign bus.fire_tag  = r_fire_tag;
    assign bus.fire_port = r_fire_port;
    assign bus.busy      = r_busy;
    assign bus.err_sel   = r_err_sel;

`ifdef DDF_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] r_cnt [FLUX];
    logic [CNT_WIDTH-1:0] r_stat_count;

    // Counted during the fire cycle itself; bad-select discards never assert fire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int f = 0; f < FLUX; f++)
                r_cnt[f] <= '0;
            r_stat_count <= '0;
        end else begin
            for (int f = 0; f < FLUX; f++) begin
                if (r_fire && r_fire_tag == TAG_WIDTH'(f) && r_cnt[f] != '1)
                    r_cnt[f] <= r_cnt[f] + 1'b1;
            end
            r_stat_count <= '0;
            for (int f = 0; f < FLUX; f++) begin
                if (bus.stat_sel == TAG_WIDTH'(f))
                    r_stat_count <= r_cnt[f];
            end
        end
    end

    assign bus.stat_count = r_stat_count;
`endif

endmodule

`default_nettype wire
